// File: rtl/mem_arb_if.sv
// Bus bundle for mem_arb: fetch port, load/store port and the shared memory bus.
// slave is the arbiter's view; master is the view of the surrounding core/memory.
interface mem_arb_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        ls_req;
   logic        ls_we;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [3:0]  ls_be;
   logic        ls_gnt;
   logic        ls_rvalid;
   logic [31:0] ls_rdata;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
      output ls_gnt, ls_rvalid, ls_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
      input  ls_gnt, ls_rvalid, ls_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/mem_arb.sv
// Single-port memory arbiter: load/store has priority, fetch is protected from
// starvation; one outstanding bus transaction, response routed back to its owner.
module mem_arb #(
   parameter int STARVE_MAX = 4
) (
   input  logic      clk,
   input  logic      rst,
   mem_arb_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

   localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

   state_t      r_state, w_state_nxt;
   owner_t      r_owner;
   logic [3:0]  r_starve;
   logic        r_mem_req, r_mem_we;
   logic [31:0] r_mem_addr, r_mem_wdata;
   logic [3:0]  r_mem_be;

   logic        w_sel_ls, w_sel_if, w_if_gnt, w_ls_gnt, w_done;
   logic        w_if_rvalid, w_ls_rvalid;
   logic [31:0] w_if_rdata, w_ls_rdata;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_sel_ls || w_sel_if) w_state_nxt = S_REQ;
         S_REQ:  if (bus.mem_gnt) w_state_nxt = bus.mem_rvalid ? S_IDLE : S_WAIT;
         S_WAIT: if (bus.mem_rvalid) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // LS wins unless fetch has waited through STARVE_MAX LS grants.
   always_comb begin
      w_sel_ls    = bus.ls_req && ((r_starve < LP_STARVE_MAX) || !bus.if_req);
      w_sel_if    = bus.if_req && !w_sel_ls;
      w_if_gnt    = (r_state == S_IDLE) && w_sel_if;
      w_ls_gnt    = (r_state == S_IDLE) && w_sel_ls;
      w_done      = ((r_state == S_REQ) && bus.mem_gnt && bus.mem_rvalid) ||
                    ((r_state == S_WAIT) && bus.mem_rvalid);
      w_if_rvalid = w_done && (r_owner == OWN_IF);
      w_ls_rvalid = w_done && (r_owner == OWN_LS);
      w_if_rdata  = w_if_rvalid ? bus.mem_rdata : 32'h0;
      w_ls_rdata  = w_ls_rvalid ? bus.mem_rdata : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner     <= OWN_IF;
         r_starve    <= 4'd0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_wdata <= 32'h0;
         r_mem_be    <= 4'h0;
      end else begin
         if (!bus.if_req || w_if_gnt)
            r_starve <= 4'd0;
         else if (w_ls_gnt && (r_starve < LP_STARVE_MAX))
            r_starve <= r_starve + 4'd1;

         if (w_ls_gnt) begin
            r_owner     <= OWN_LS;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.ls_we;
            r_mem_addr  <= bus.ls_addr;
            r_mem_wdata <= bus.ls_wdata;
            r_mem_be    <= bus.ls_be;
         end else if (w_if_gnt) begin
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_mem_wdata <= 32'h0;
            r_mem_be    <= 4'hF;
         end else if ((r_state == S_REQ) && bus.mem_gnt) begin
            r_mem_req   <= 1'b0;
         end
      end
   end

   assign bus.if_gnt    = w_if_gnt;
   assign bus.ls_gnt    = w_ls_gnt;
   assign bus.if_rvalid = w_if_rvalid;
   assign bus.ls_rvalid = w_ls_rvalid;
   assign bus.if_rdata  = w_if_rdata;
   assign bus.ls_rdata  = w_ls_rdata;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_be    = r_mem_be;
endmodule
